obj_motion_engine: RTL

Game-state stage that owns the positions and velocities of the on-screen objects and advances them once per game tick. It publishes a coherent snapshot of all object locations, packed {x[10:0], y[9:0]}, together with a one-cycle valid strobe. These outputs feed the `displaying` block's `game_obj_loc` and `valid_in` inputs directly, on the same 100 MHz clock. It replaces the hard-coded location array and the free-running valid divider that currently drive `displaying`.

---
 rtl/obj_motion_engine.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/obj_motion_engine.sv
// obj_motion_engine: owns object positions/velocities, advances them once per game tick
// and publishes a coherent {x[10:0], y[9:0]} snapshot with a one-cycle valid strobe.
module obj_motion_engine #(
   parameter int NUM_OBJ     = 6,
   parameter int TICK_CYCLES = 50000,
   parameter int X_MAX       = 1279,
   parameter int Y_MAX       = 719
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  en_in,
   input  logic                  load_valid_in,
   input  logic [2:0]            load_idx_in,
   input  logic [10:0]           load_x_in,
   input  logic [9:0]            load_y_in,
   input  logic [3:0]            load_vx_in,
   input  logic [3:0]            load_vy_in,
   output logic                  load_ready_out,
   output logic [NUM_OBJ*21-1:0] obj_loc_out,
   output logic                  valid_out,
   output logic                  busy_out,
   output logic [15:0]           frame_cnt_out
);
   localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_PUBLISH} state_t;

   state_t                 state_q, state_d;
   logic [2:0]             idx_q, idx_d;
   logic                   pend_q, pend_d;
   logic [CNT_W-1:0]       tick_cnt_q, tick_cnt_d;
   logic                   tick;
   logic                   do_load;
   logic [NUM_OBJ*21-1:0]  obj_loc_q;
   logic                   valid_q, busy_q;
   logic [15:0]            frame_cnt_q;

   logic [10:0]            x_q  [NUM_OBJ];
   logic [9:0]             y_q  [NUM_OBJ];
   logic signed [3:0]      vx_q [NUM_OBJ];
   logic signed [3:0]      vy_q [NUM_OBJ];

   logic [10:0]            cur_x;
   logic [9:0]             cur_y;
   logic signed [3:0]      cur_vx, cur_vy;
   logic [14:0]            xstep, ystep;
   logic                   unused_ystep_msb;

   // Returns {new_vel, new_pos}; a wall hit pins the coordinate and reverses velocity.
   function automatic logic [14:0] step_axis(input logic [10:0] pos,
                                             input logic signed [3:0] vel,
                                             input logic [10:0] lim);
      logic signed [11:0] np;
      np = $signed({1'b0, pos}) + $signed({{8{vel[3]}}, vel});
      if (np < 12'sd0)
         return {-vel, 11'd0};
      else if (np > $signed({1'b0, lim}))
         return {-vel, lim};
      else
         return {vel, np[10:0]};
   endfunction

   function automatic logic signed [3:0] clamp_vel(input logic [3:0] v);
      return (v == 4'b1000) ? 4'sb1001 : $signed(v);
   endfunction

   always_comb begin
      tick       = 1'b0;
      tick_cnt_d = tick_cnt_q;
      if (en_in) begin
         if (tick_cnt_q == CNT_W'(TICK_CYCLES - 1)) begin
            tick       = 1'b1;
            tick_cnt_d = '0;
         end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      pend_d         = pend_q;
      do_load        = 1'b0;
      load_ready_out = 1'b0;
      case (state_q)
         S_IDLE: begin
            load_ready_out = 1'b1;
            if (load_valid_in) begin
               do_load = 1'b1;
               if (tick) pend_d = 1'b1;
            end else if (tick || pend_q) begin
               state_d = S_UPDATE;
               idx_d   = 3'd0;
               pend_d  = 1'b0;
            end
         end
         S_UPDATE: begin
            if (tick) pend_d = 1'b1;
            if (idx_q == 3'(NUM_OBJ - 1)) state_d = S_PUBLISH;
            else                          idx_d   = idx_q + 3'd1;
         end
         S_PUBLISH: begin
            if (tick) pend_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q     <= S_IDLE;
         idx_q       <= 3'd0;
         pend_q      <= 1'b0;
         tick_cnt_q  <= '0;
         obj_loc_q   <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         pend_q     <= pend_d;
         tick_cnt_q <= tick_cnt_d;
         busy_q     <= (state_d != S_IDLE);
         valid_q    <= (state_q == S_PUBLISH);
         if (state_q == S_PUBLISH) begin
            for (int i = 0; i < NUM_OBJ; i++)
               obj_loc_q[i*21 +: 21] <= {x_q[i], y_q[i]};
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   // One shared stepper serves the object selected by the sweep index.
   always_comb begin
      cur_x  = '0;
      cur_y  = '0;
      cur_vx = '0;
      cur_vy = '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (idx_q == 3'(i)) begin
            cur_x  = x_q[i];
            cur_y  = y_q[i];
            cur_vx = vx_q[i];
            cur_vy = vy_q[i];
         end
      end
      xstep = step_axis(cur_x, cur_vx, 11'(X_MAX));
      ystep = step_axis({1'b0, cur_y}, cur_vy, 11'(Y_MAX));
   end

   assign unused_ystep_msb = ystep[10];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            x_q[i]  <= '0;
            y_q[i]  <= '0;
            vx_q[i] <= '0;
            vy_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_OBJ; i++) begin
            if (do_load && load_idx_in == 3'(i)) begin
               x_q[i]  <= (load_x_in > 11'(X_MAX)) ? 11'(X_MAX) : load_x_in;
               y_q[i]  <= (load_y_in > 10'(Y_MAX)) ? 10'(Y_MAX) : load_y_in;
               vx_q[i] <= clamp_vel(load_vx_in);
               vy_q[i] <= clamp_vel(load_vy_in);
            end else if (state_q == S_UPDATE && idx_q == 3'(i)) begin
               x_q[i]  <= xstep[10:0];
               vx_q[i] <= xstep[14:11];
               y_q[i]  <= ystep[9:0];
               vy_q[i] <= ystep[14:11];
            end
         end
      end
   end

   assign obj_loc_out   = obj_loc_q;
   assign valid_out     = valid_q;
   assign busy_out      = busy_q;
   assign frame_cnt_out = frame_cnt_q;

endmodule
